// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes and the master bridge state encoding.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } axi_mst_state_t;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding command/response port to AXI4-Lite master bridge.
// One transaction in flight; misaligned commands are answered locally with SLVERR.
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [2:0]  AXI_PROT           = 3'b000
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_aresetn,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  axi_mst_state_t state_q, state_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           awvalid_q, awvalid_d;
  logic           wvalid_q, wvalid_d;
  logic           arvalid_q, arvalid_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [SW-1:0]  wstrb_q, wstrb_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  axi_resp_t      resp_q, resp_d;
  logic           aw_hs, w_hs;

  assign aw_hs = awvalid_q && m_axi_awready;
  assign w_hs  = wvalid_q && m_axi_wready;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          rdata_d = '0;
          resp_d  = OKAY;
          if (cmd_addr[1:0] != 2'b00) begin
            resp_d  = SLVERR;
            state_d = ST_RSP;
          end else if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        // AW and W complete independently; move on once both have handshaked.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          resp_d  = axi_resp_t'(m_axi_bresp);
          rdata_d = '0;
          state_d = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = axi_resp_t'(m_axi_rresp);
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered so cmd_ready reads 0 while reset is held and rises one edge after release.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= OKAY;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = (state_q == ST_RSP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == ST_WR_RESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = AXI_PROT;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == ST_RD_DATA);

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge with a delay-configurable AXI4-Lite slave model.
module tb_axi_lite_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, s_rdata;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  s_bresp, s_rresp;

  always #5 clk = ~clk;

  axi_lite_master_bridge dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(s_bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(s_rdata), .m_axi_rresp(s_rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Slave configuration (written by the stimulus block only)
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  // Monitor state (written by the slave/monitor block only)
  int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, cmd_hs = 0, rsp_hs = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, cmd_hs_cyc = 0;
  int aw_rise_cyc = 0, aw_fall_cyc = 0, w_fall_cyc = 0, rsp_rise_cyc = 0;
  int aw_cycles = 0, w_cycles = 0, ar_cycles = 0, rsp_cycles = 0;
  int rsp_unstable = 0, cmd_ready_in_rsp = 0;
  logic [31:0] aw_addr_cap = 0, w_data_cap = 0, ar_addr_cap = 0, rsp_rdata_cap = 0, held_rdata = 0;
  logic [3:0]  w_strb_cap = 0;
  logic [1:0]  rsp_resp_cap = 0, held_resp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and monitor: readies are set at negedge, so a handshake seen here
  // completes on the following posedge.
  initial begin : slave_mon
    int aw_cnt, w_cnt, ar_cnt;
    logic aw_got, w_got, b_issue, b_drop, r_issue, r_drop, prev_aw, prev_w, prev_rsp;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    aw_got = 0; w_got = 0; b_issue = 0; b_drop = 0; r_issue = 0; r_drop = 0;
    prev_aw = 0; prev_w = 0; prev_rsp = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    s_bresp = 0; s_rresp = 0; s_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_got = 0; w_got = 0; b_issue = 0; b_drop = 0; r_issue = 0; r_drop = 0;
        prev_aw = 0; prev_w = 0; prev_rsp = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      end else begin
        if (b_drop) begin bvalid = 0; b_drop = 0; end
        if (b_issue) begin bvalid = 1; s_bresp = bresp_cfg; b_issue = 0; end
        if (r_drop) begin rvalid = 0; r_drop = 0; end
        if (r_issue) begin rvalid = 1; s_rresp = rresp_cfg; s_rdata = rdata_cfg; r_issue = 0; end
        awready = awvalid && (aw_cnt >= aw_delay);
        wready  = wvalid && (w_cnt >= w_delay);
        arready = arvalid && (ar_cnt >= ar_delay);
        if (awvalid) aw_cycles++;
        if (wvalid) w_cycles++;
        if (arvalid) ar_cycles++;
        if (awvalid && !prev_aw) aw_rise_cyc = cyc;
        if (!awvalid && prev_aw) aw_fall_cyc = cyc;
        if (!wvalid && prev_w) w_fall_cyc = cyc;
        prev_aw = awvalid; prev_w = wvalid;
        if (awvalid && awready) begin
          aw_hs++; aw_hs_cyc = cyc; aw_cnt = 0; aw_got = 1; aw_addr_cap = awaddr;
        end else if (awvalid) aw_cnt++;
        if (wvalid && wready) begin
          w_hs++; w_hs_cyc = cyc; w_cnt = 0; w_got = 1; w_data_cap = wdata; w_strb_cap = wstrb;
        end else if (wvalid) w_cnt++;
        if (arvalid && arready) begin
          ar_hs++; ar_cnt = 0; r_issue = 1; ar_addr_cap = araddr;
        end else if (arvalid) ar_cnt++;
        if (aw_got && w_got) begin b_issue = 1; aw_got = 0; w_got = 0; end
        if (bvalid && bready) begin b_hs++; b_drop = 1; end
        if (rvalid && rready) begin r_hs++; r_drop = 1; end
        if (cmd_valid && cmd_ready) begin cmd_hs++; cmd_hs_cyc = cyc; end
        if (rsp_valid) begin
          rsp_cycles++;
          if (!prev_rsp) rsp_rise_cyc = cyc;
          else if (rsp_rdata !== held_rdata || rsp_resp !== held_resp) rsp_unstable++;
          held_rdata = rsp_rdata; held_resp = rsp_resp;
          if (cmd_ready) cmd_ready_in_rsp++;
          if (rsp_ready) begin rsp_hs++; rsp_rdata_cap = rsp_rdata; rsp_resp_cap = rsp_resp; end
        end
        prev_rsp = rsp_valid && !rsp_ready;
      end
    end
  end

  task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin errors++; $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_hs < target && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (rsp_hs < target) begin errors++; $display("FAIL rsp_timeout: rsp count %0d required %0d", rsp_hs, target); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 1;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 7'b0) begin
      errors++; $display("FAIL reset_handshakes: got %b required 0000000",
                         {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    checks++;
    if ({awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp} !== '0) begin
      errors++; $display("FAIL reset_payload: awaddr=%h araddr=%h wdata=%h wstrb=%h rdata=%h resp=%b required all 0",
                         awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp);
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready_before_edge: got %b required 0", cmd_ready); end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready_idle: got %b required 1", cmd_ready); end
    $display("reset: cmd_ready=%b", cmd_ready);
  endtask

  task automatic test_write_zero_wait;
    int aw0, w0, b0, r0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; r0 = rsp_hs;
    aw_delay = 0; w_delay = 0; bresp_cfg = 2'b00; rsp_ready = 1;
    start_cmd(1'b1, 32'h0, 32'h1, 4'hF);
    wait_rsp(r0 + 1);
    checks++;
    if ({aw_hs - aw0, w_hs - w0, b_hs - b0} !== {32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL wr0_handshakes: aw=%0d w=%0d b=%0d required 1 1 1", aw_hs - aw0, w_hs - w0, b_hs - b0);
    end
    checks++;
    if (aw_rise_cyc - cmd_hs_cyc !== 1) begin
      errors++; $display("FAIL wr0_aw_latency: got %0d required 1", aw_rise_cyc - cmd_hs_cyc);
    end
    checks++;
    if (rsp_rise_cyc - cmd_hs_cyc !== 3) begin
      errors++; $display("FAIL wr0_rsp_latency: got %0d required 3", rsp_rise_cyc - cmd_hs_cyc);
    end
    checks++;
    if (aw_addr_cap !== 32'h0 || w_data_cap !== 32'h1 || w_strb_cap !== 4'hF) begin
      errors++; $display("FAIL wr0_payload: addr=%h data=%h strb=%h required 00000000 00000001 f",
                         aw_addr_cap, w_data_cap, w_strb_cap);
    end
    checks++;
    if (rsp_resp_cap !== 2'b00 || rsp_rdata_cap !== 32'h0) begin
      errors++; $display("FAIL wr0_rsp: resp=%b rdata=%h required 00 00000000", rsp_resp_cap, rsp_rdata_cap);
    end
    $display("write 0x0 zero-wait: resp=%b rdata=%h", rsp_resp_cap, rsp_rdata_cap);
  endtask

  task automatic test_read_delay;
    int ar0, r0;
    ar0 = ar_cycles; r0 = rsp_hs;
    ar_delay = 2; rdata_cfg = 32'h0000_0100; rresp_cfg = 2'b00; rsp_ready = 1;
    start_cmd(1'b0, 32'h14, 32'h0, 4'h0);
    wait_rsp(r0 + 1);
    checks++;
    if (ar_cycles - ar0 !== 3) begin errors++; $display("FAIL rd_arvalid_cycles: got %0d required 3", ar_cycles - ar0); end
    checks++;
    if (ar_addr_cap !== 32'h14) begin errors++; $display("FAIL rd_araddr: got %h required 00000014", ar_addr_cap); end
    checks++;
    if (rsp_rdata_cap !== 32'h0000_0100 || rsp_resp_cap !== 2'b00) begin
      errors++; $display("FAIL rd_rsp: rdata=%h resp=%b required 00000100 00", rsp_rdata_cap, rsp_resp_cap);
    end
    ar_delay = 0;
    $display("read 0x14 ar delay 2: rdata=%h resp=%b", rsp_rdata_cap, rsp_resp_cap);
  endtask

  task automatic test_write_skew;
    for (int k = 0; k < 2; k++) begin
      int aw0, w0, b0, r0;
      aw0 = aw_cycles; w0 = w_cycles; b0 = b_hs; r0 = rsp_hs;
      aw_delay = (k == 0) ? 4 : 0;
      w_delay  = (k == 0) ? 0 : 4;
      start_cmd(1'b1, 32'h40 + 32'(k * 4), 32'hA5A5_0000 + 32'(k), 4'h3);
      wait_rsp(r0 + 1);
      checks++;
      if (aw_fall_cyc !== aw_hs_cyc + 1 || w_fall_cyc !== w_hs_cyc + 1) begin
        errors++; $display("FAIL skew%0d_drop: aw hs %0d fall %0d, w hs %0d fall %0d required fall = hs+1",
                           k, aw_hs_cyc, aw_fall_cyc, w_hs_cyc, w_fall_cyc);
      end
      checks++;
      if (aw_cycles - aw0 !== ((k == 0) ? 5 : 1) || w_cycles - w0 !== ((k == 0) ? 1 : 5)) begin
        errors++; $display("FAIL skew%0d_valid_cycles: aw=%0d w=%0d required %0d %0d",
                           k, aw_cycles - aw0, w_cycles - w0, (k == 0) ? 5 : 1, (k == 0) ? 1 : 5);
      end
      checks++;
      if (b_hs - b0 !== 1 || rsp_resp_cap !== 2'b00) begin
        errors++; $display("FAIL skew%0d_bresp: b count %0d resp %b required 1 00", k, b_hs - b0, rsp_resp_cap);
      end
      $display("write skew %0d: aw_hs=%0d w_hs=%0d resp=%b", k, aw_hs_cyc, w_hs_cyc, rsp_resp_cap);
    end
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_misaligned;
    int ar0, arc0, r0;
    ar0 = ar_hs; arc0 = ar_cycles; r0 = rsp_hs;
    rsp_ready = 1;
    start_cmd(1'b0, 32'h0000_0006, 32'h0, 4'h0);
    wait_rsp(r0 + 1);
    checks++;
    if (ar_hs - ar0 !== 0 || ar_cycles - arc0 !== 0) begin
      errors++; $display("FAIL mis_no_ar: ar hs %0d arvalid cycles %0d required 0 0", ar_hs - ar0, ar_cycles - arc0);
    end
    checks++;
    if (rsp_rise_cyc - cmd_hs_cyc !== 1) begin
      errors++; $display("FAIL mis_latency: got %0d required 1", rsp_rise_cyc - cmd_hs_cyc);
    end
    checks++;
    if (rsp_resp_cap !== 2'b10 || rsp_rdata_cap !== 32'h0) begin
      errors++; $display("FAIL mis_rsp: resp=%b rdata=%h required 10 00000000", rsp_resp_cap, rsp_rdata_cap);
    end
    $display("misaligned read 0x6: resp=%b", rsp_resp_cap);
  endtask

  task automatic test_rsp_hold;
    int c0, u0, cr0, r0, n;
    c0 = rsp_cycles; u0 = rsp_unstable; cr0 = cmd_ready_in_rsp; r0 = rsp_hs;
    rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b11; rsp_ready = 0;
    start_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!rsp_valid) begin errors++; $display("FAIL hold_rsp_timeout: rsp_valid=%b required 1", rsp_valid); end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1;
    wait_rsp(r0 + 1);
    @(negedge clk);
    checks++;
    if (rsp_cycles - c0 !== 6) begin errors++; $display("FAIL hold_valid_cycles: got %0d required 6", rsp_cycles - c0); end
    checks++;
    if (rsp_unstable - u0 !== 0 || cmd_ready_in_rsp - cr0 !== 0) begin
      errors++; $display("FAIL hold_stable: changes %0d cmd_ready_in_rsp %0d required 0 0",
                         rsp_unstable - u0, cmd_ready_in_rsp - cr0);
    end
    checks++;
    if (rsp_rdata_cap !== 32'hDEAD_BEEF || rsp_resp_cap !== 2'b11) begin
      errors++; $display("FAIL hold_rsp: rdata=%h resp=%b required deadbeef 11", rsp_rdata_cap, rsp_resp_cap);
    end
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL hold_idle: cmd_ready=%b rsp_valid=%b required 1 0", cmd_ready, rsp_valid);
    end
    rresp_cfg = 2'b00;
    $display("read DECERR held: rdata=%h resp=%b", rsp_rdata_cap, rsp_resp_cap);
  endtask

  task automatic test_reset_mid;
    int r0, c0, n;
    r0 = rsp_hs; c0 = rsp_cycles;
    aw_delay = 30; w_delay = 30; rsp_ready = 1;
    start_cmd(1'b1, 32'h80, 32'h1234, 4'hF);
    n = 0;
    while (!awvalid && n < 20) begin @(negedge clk); n++; end
    #2 rst_n = 0;
    #1;
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: awvalid=%b wvalid=%b cmd_ready=%b required 0 0 0", awvalid, wvalid, cmd_ready);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    aw_delay = 0; w_delay = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (rsp_hs - r0 !== 0 || rsp_cycles - c0 !== 0) begin
      errors++; $display("FAIL midrst_no_rsp: rsp count %0d valid cycles %0d required 0 0", rsp_hs - r0, rsp_cycles - c0);
    end
    rdata_cfg = 32'h1234_5678;
    start_cmd(1'b0, 32'h24, 32'h0, 4'h0);
    wait_rsp(r0 + 1);
    checks++;
    if (rsp_rdata_cap !== 32'h1234_5678 || rsp_resp_cap !== 2'b00 || ar_addr_cap !== 32'h24) begin
      errors++; $display("FAIL midrst_read: rdata=%h resp=%b araddr=%h required 12345678 00 00000024",
                         rsp_rdata_cap, rsp_resp_cap, ar_addr_cap);
    end
    $display("reset mid-write then read 0x24: rdata=%h resp=%b", rsp_rdata_cap, rsp_resp_cap);
  endtask

  initial begin
    test_reset;
    test_write_zero_wait;
    test_read_delay;
    test_write_skew;
    test_misaligned;
    test_rsp_hold;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
